// File: rtl/serial_adder.sv
// Bit-serial ripple adder: a single full-adder slice plus a carry flop, LSB first, with a start/busy/done handshake.
// Define SERIAL_ADDER_SUB_EN to add the `sub` port and a two's-complement subtract mode.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned      CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_sr_q,  a_sr_d;
    logic [WIDTH-1:0] b_sr_q,  b_sr_d;
    logic [WIDTH-1:0] acc_q,   acc_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [WIDTH-1:0] sum_q,   sum_d;
    logic             cout_q,  cout_d;
    logic             ovf_q,   ovf_d;
    logic             sub_q;

`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_d;
`else
    assign sub_q = 1'b0;
`endif

    logic slice_a, slice_b, slice_s, slice_c;

    always_comb begin
        slice_a = a_sr_q[0];
        slice_b = b_sr_q[0] ^ sub_q;
        slice_s = slice_a ^ slice_b ^ carry_q;
        slice_c = (slice_a & slice_b) | (slice_a & carry_q) | (slice_b & carry_q);
    end

    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef SERIAL_ADDER_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            // DONE accepts a new request exactly like IDLE, giving back-to-back operation.
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sr_d  = a;
                    b_sr_d  = b;
                    cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                acc_d   = {slice_s, acc_q[WIDTH-1:1]};
                carry_d = slice_c;
                // On the MSB slice carry_q is the carry into the MSB and slice_c the carry out.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    sum_d   = {slice_s, acc_q[WIDTH-1:1]};
                    cout_d  = slice_c;
                    ovf_d   = carry_q ^ slice_c;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

`ifdef SERIAL_ADDER_SUB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sub_q <= 1'b0;
        end else begin
            sub_q <= sub_d;
        end
    end
`endif

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a scoreboard of expected results is filled at request time and drained on done.
// Subtract tests are built only when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub_i;
`endif
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];
    exp_t held = '0;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a_i),
        .b     (b_i),
        .cin   (cin_i),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub_i),
`endif
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .ovf   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference arithmetic done at full width, independent of the bit-serial structure.
    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic c, input logic s);
        exp_t         r;
        logic [W-1:0] yy;
        logic [W:0]   t;
        logic         cc;
        yy     = s ? ~y : y;
        cc     = s ? 1'b1 : c;
        t      = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, cc};
        r.sum  = t[W-1:0];
        r.cout = t[W];
        r.ovf  = (x[W-1] == yy[W-1]) && (t[W-1] != x[W-1]);
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", 64'(done), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum",  64'(sum),  64'(e.sum));
                    check("cout", 64'(cout), 64'(e.cout));
                    check("ovf",  64'(ovf),  64'(e.ovf));
                    held = e;
                end
            end else begin
                check("hold", 64'({sum, cout, ovf}), 64'({held.sum, held.cout, held.ovf}));
            end
        end
    end

    task automatic wait_done(input int unsigned cyc0);
        int unsigned cyc;
        cyc = cyc0;
        while (!done && cyc < W + 4) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!done) check("done_timeout", 64'(done), 64'(1));
        else       check("latency", 64'(cyc), 64'(W));
    endtask

    // Caller is just after a rising edge with the DUT in IDLE or DONE.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts);
        a_i   = ta;
        b_i   = tb;
        cin_i = tc;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = ts;
`endif
        start = 1'b1;
        sb.push_back(model(ta, tb, tc, ts));
        @(posedge clk); #1;
        start = 1'b0;
        a_i   = W'($urandom);
        b_i   = W'($urandom);
        cin_i = 1'($urandom);
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'($urandom);
`endif
        check("busy_on_accept", 64'(busy), 64'(1));
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic ts, input bit idle_after);
        launch(ta, tb, tc, ts);
        wait_done(0);
        if (idle_after) begin
            @(posedge clk); #1;
            check("idle_busy", 64'(busy), 64'(0));
            check("idle_done", 64'(done), 64'(0));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_i   = '0;
        b_i   = '0;
        cin_i = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub_i = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_sum",  64'(sum),  64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf",  64'(ovf),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op(8'h35, 8'h4A, 1'b0, 1'b0, 1'b1);
        check("t1_sum_lit", 64'(sum), 64'(8'h7F));
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
        check("t2_cout_lit", 64'(cout), 64'(1));
        run_op(8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 1'b1);
        check("t3_ovf_lit", 64'(ovf), 64'(1));
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 1'b1);

        // Start pulses during RUN must be ignored, then a request held in DONE chains directly.
        launch(8'h10, 8'h20, 1'b0, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        a_i   = 8'hAA;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3);
        check("t4_sum_lit", 64'(sum), 64'(8'h30));
        launch(8'h01, 8'h05, 1'b0, 1'b0);
        check("t4_b2b_done", 64'(done), 64'(0));
        wait_done(0);
        @(posedge clk); #1;

        // Asynchronous reset in the fourth RUN cycle discards the operation.
        launch(8'h55, 8'h33, 1'b0, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        sb.delete();
        held = '0;
        #1;
        check("t5_busy", 64'(busy), 64'(0));
        check("t5_done", 64'(done), 64'(0));
        check("t5_sum",  64'(sum),  64'(0));
        check("t5_cout", 64'(cout), 64'(0));
        check("t5_ovf",  64'(ovf),  64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(8'h01, 8'h02, 1'b0, 1'b0, 1'b1);
        check("t5_sum_lit", 64'(sum), 64'(8'h03));

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 1'b1);
        check("t6_sub_sum", 64'(sum), 64'(8'h0F));
        run_op(8'h00, 8'h01, 1'b1, 1'b1, 1'b1);
        check("t6_borrow", 64'(cout), 64'(0));
        run_op(8'h80, 8'h01, 1'b0, 1'b1, 1'b1);
        check("t6_sub_ovf", 64'(ovf), 64'(1));
`endif

        for (int i = 0; i < 16; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom),
`ifdef SERIAL_ADDER_SUB_EN
                   1'($urandom),
`else
                   1'b0,
`endif
                   (i % 2) == 0);
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("sb_empty", 64'(sb.size()), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
